// File: rtl/vmem_fill_engine_pkg.sv
// Shared definitions for the vmem rectangle-fill engine.
//   - default display geometry
//   - register word offsets and CTRL/STATUS bit positions
//   - FSM state encoding
//   - clip helper that bounds one rectangle extent against the display edge
package vmem_fill_engine_pkg;

  localparam int unsigned DispWDefault = 240;
  localparam int unsigned DispHDefault = 240;

  localparam logic [1:0] RegOrigin = 2'd0;
  localparam logic [1:0] RegSize   = 2'd1;
  localparam logic [1:0] RegColor  = 2'd2;
  localparam logic [1:0] RegCtrl   = 2'd3;

  localparam int unsigned CtrlStartBit   = 0;
  localparam int unsigned CtrlClrDoneBit = 1;
  localparam int unsigned CtrlAbortBit   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StFill,
    StDone
  } fill_state_e;

  // Visible extent of a span starting at org with length len on an axis of size lim.
  function automatic logic [8:0] clip_extent(input logic [7:0] org, input logic [8:0] len,
                                             input logic [8:0] lim);
    logic [8:0] room;
    room = lim - {1'b0, org};
    if ({1'b0, org} >= lim) return 9'd0;
    return (len < room) ? len : room;
  endfunction

endpackage

// File: rtl/vmem_fill_engine_if.sv
// Register bus, CPU direct-store path and merged vmem write port of the fill engine.
//   reg_*  : memory-mapped register access (write strobe, read strobe, 2-bit word offset)
//   cpu_*  : CPU direct vmem store, passed through with priority
//   vmem_* : merged vmem write port, {y,x} addressed
// slave is the engine's view, master the view of whoever drives the bus.
interface vmem_fill_engine_if;
  logic        reg_we_i;
  logic        reg_re_i;
  logic [1:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;
  logic        cpu_we_i;
  logic [15:0] cpu_addr_i;
  logic [15:0] cpu_wdata_i;
  logic        vmem_we_o;
  logic [15:0] vmem_addr_o;
  logic [15:0] vmem_wdata_o;

  modport slave (
    input  reg_we_i, reg_re_i, reg_addr_i, reg_wdata_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output reg_rdata_o, vmem_we_o, vmem_addr_o, vmem_wdata_o
  );

  modport master (
    output reg_we_i, reg_re_i, reg_addr_i, reg_wdata_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  reg_rdata_o, vmem_we_o, vmem_addr_o, vmem_wdata_o
  );
endinterface

// File: rtl/vmem_fill_raster.sv
// Raster position generator for the fill engine.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : latch origin and clipped extents, position goes to the origin
//   adv_i        : step to the next pixel, x innermost
//   x0_i, y0_i   : origin
//   ew_i, eh_i   : clipped width/height (non-zero when loaded for a fill)
//   addr_o       : current pixel address {y[7:0], x[7:0]}
//   last_o       : current pixel is the final one of the rectangle
module vmem_fill_raster (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        adv_i,
  input  logic [7:0]  x0_i,
  input  logic [7:0]  y0_i,
  input  logic [8:0]  ew_i,
  input  logic [8:0]  eh_i,
  output logic [15:0] addr_o,
  output logic        last_o
);

  logic [8:0] r_x0;
  logic [8:0] r_x;
  logic [8:0] r_y;
  logic [8:0] r_xend;
  logic [8:0] r_yend;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_x0   <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_xend <= '0;
      r_yend <= '0;
    end else if (load_i) begin
      r_x0   <= {1'b0, x0_i};
      r_x    <= {1'b0, x0_i};
      r_y    <= {1'b0, y0_i};
      // Inclusive end coordinates; clipping keeps them inside the display.
      r_xend <= {1'b0, x0_i} + ew_i - 9'd1;
      r_yend <= {1'b0, y0_i} + eh_i - 9'd1;
    end else if (adv_i) begin
      if (r_x == r_xend) begin
        r_x <= r_x0;
        r_y <= r_y + 9'd1;
      end else begin
        r_x <= r_x + 9'd1;
      end
    end
  end

  assign addr_o = {r_y[7:0], r_x[7:0]};
  assign last_o = (r_x == r_xend) && (r_y == r_yend);

endmodule

// File: rtl/vmem_fill_engine.sv
// Rectangle-fill accelerator merged in front of the vmem write port.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus_io       : register bus, CPU store path and merged vmem write port
//   busy_o       : fill in progress (SETUP or FILL)
//   done_o       : one-cycle pulse when a fill completes normally
// CPU stores always win the vmem port; the engine stalls its raster in those cycles.
module vmem_fill_engine
  import vmem_fill_engine_pkg::*;
#(
  parameter int unsigned DISP_W = DispWDefault,
  parameter int unsigned DISP_H = DispHDefault
) (
  input  logic                clk_i,
  input  logic                rst_i,
  vmem_fill_engine_if.slave   bus_io,
  output logic                busy_o,
  output logic                done_o
);

  fill_state_e r_state, w_state_d;
  logic [15:0] r_origin;
  logic [8:0]  r_w;
  logic [8:0]  r_h;
  logic [15:0] r_color;
  logic [15:0] r_fill_color;
  logic        r_done_sticky;
  logic [31:0] r_rdata;

  logic        w_ctrl_wr, w_start, w_clr_done, w_abort;
  logic [8:0]  w_ew, w_eh;
  logic        w_load, w_adv, w_eng_we, w_done, w_last;
  logic [15:0] w_px_addr;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_ctrl_wr  = bus_io.reg_we_i && (bus_io.reg_addr_i == RegCtrl);
  assign w_start    = w_ctrl_wr && bus_io.reg_wdata_i[CtrlStartBit];
  assign w_clr_done = w_ctrl_wr && bus_io.reg_wdata_i[CtrlClrDoneBit];
  assign w_abort    = w_ctrl_wr && bus_io.reg_wdata_i[CtrlAbortBit];
  assign w_unused   = ^{bus_io.reg_wdata_i[31:25], bus_io.reg_wdata_i[15:9]};

  assign w_ew = clip_extent(r_origin[7:0], r_w, 9'(DISP_W));
  assign w_eh = clip_extent(r_origin[15:8], r_h, 9'(DISP_H));

  vmem_fill_raster u_raster (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (w_load),
    .adv_i  (w_adv),
    .x0_i   (r_origin[7:0]),
    .y0_i   (r_origin[15:8]),
    .ew_i   (w_ew),
    .eh_i   (w_eh),
    .addr_o (w_px_addr),
    .last_o (w_last)
  );

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    w_adv     = 1'b0;
    w_eng_we  = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      StIdle:  if (w_start) w_state_d = StSetup;
      StSetup: begin
        w_load    = 1'b1;
        w_state_d = (w_ew == 9'd0 || w_eh == 9'd0) ? StDone : StFill;
      end
      StFill: begin
        if (!bus_io.cpu_we_i) begin
          w_eng_we = 1'b1;
          w_adv    = 1'b1;
          if (w_last) w_state_d = StDone;
        end
      end
      StDone: begin
        w_done    = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    // Abort takes effect in the cycle it is written: no pixel, no done.
    if (w_abort) begin
      w_state_d = StIdle;
      w_load    = 1'b0;
      w_adv     = 1'b0;
      w_eng_we  = 1'b0;
      w_done    = 1'b0;
    end
  end

  always_comb begin
    case (bus_io.reg_addr_i)
      RegOrigin: w_rdata = {16'd0, r_origin};
      RegSize:   w_rdata = {7'd0, r_h, 7'd0, r_w};
      RegColor:  w_rdata = {16'd0, r_color};
      default:   w_rdata = {30'd0, r_done_sticky, busy_o};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= StIdle;
      r_origin      <= '0;
      r_w           <= '0;
      r_h           <= '0;
      r_color       <= '0;
      r_fill_color  <= '0;
      r_done_sticky <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_state <= w_state_d;
      if (bus_io.reg_we_i) begin
        case (bus_io.reg_addr_i)
          RegOrigin: r_origin <= bus_io.reg_wdata_i[15:0];
          RegSize: begin
            r_w <= bus_io.reg_wdata_i[8:0];
            r_h <= bus_io.reg_wdata_i[24:16];
          end
          RegColor:  r_color <= bus_io.reg_wdata_i[15:0];
          default: ;
        endcase
      end
      if (w_load) r_fill_color <= r_color;
      // Completion beats a simultaneous clear.
      if (w_done)          r_done_sticky <= 1'b1;
      else if (w_clr_done) r_done_sticky <= 1'b0;
      if (bus_io.reg_re_i) r_rdata <= w_rdata;
    end
  end

  assign busy_o              = (r_state == StSetup) || (r_state == StFill);
  assign done_o              = w_done;
  assign bus_io.reg_rdata_o  = r_rdata;
  assign bus_io.vmem_we_o    = bus_io.cpu_we_i || w_eng_we;
  assign bus_io.vmem_addr_o  = bus_io.cpu_we_i ? bus_io.cpu_addr_i : w_px_addr;
  assign bus_io.vmem_wdata_o = bus_io.cpu_we_i ? bus_io.cpu_wdata_i : r_fill_color;

endmodule

// File: tb/tb_vmem_fill_engine.sv
// Scoreboard bench for vmem_fill_engine: stimulus pushes expected vmem writes into a queue,
// a negedge monitor pops and compares every write the DUT presents.
module tb_vmem_fill_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, done;

  always #5 clk = ~clk;

  vmem_fill_engine_if ifc ();

  vmem_fill_engine #(.DISP_W(240), .DISP_H(240)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (ifc),
    .busy_o (busy),
    .done_o (done)
  );

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int done_before = 0;
  bit sb_off = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !sb_off && ifc.vmem_we_o) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL vmem_write: got %h/%h, expected no write", ifc.vmem_addr_o,
                 ifc.vmem_wdata_o);
      end else begin
        check("vmem_write", {ifc.vmem_addr_o, ifc.vmem_wdata_o}, exp_q.pop_front());
      end
    end
    if (!rst && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic push_px(input logic [7:0] x, input logic [7:0] y, input logic [15:0] c);
    exp_q.push_back({y, x, c});
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    ifc.reg_we_i = 1'b1;
    ifc.reg_addr_i = a;
    ifc.reg_wdata_i = d;
    @(posedge clk);
    #1;
    ifc.reg_we_i = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    ifc.reg_re_i = 1'b1;
    ifc.reg_addr_i = a;
    @(posedge clk);
    #1;
    ifc.reg_re_i = 1'b0;
    d = ifc.reg_rdata_o;
  endtask

  task automatic configure(input logic [15:0] org, input logic [8:0] w, input logic [8:0] h,
                           input logic [15:0] col);
    reg_write(2'd0, {16'd0, org});
    reg_write(2'd1, {7'd0, h, 7'd0, w});
    reg_write(2'd2, {16'd0, col});
  endtask

  task automatic start_fill();
    done_before = done_cnt;
    reg_write(2'd3, 32'd1);
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int n = 0;
    while (done_cnt == done_before && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (done_cnt == done_before) check({name, "_done_timeout"}, 32'd0, 32'd1);
    else check({name, "_latency"}, 32'(done_cyc - start_cyc + 1), 32'(exp_lat));
  endtask

  initial begin
    logic [31:0] rd;
    int n;
    ifc.reg_we_i = 0; ifc.reg_re_i = 0; ifc.reg_addr_i = 0; ifc.reg_wdata_i = 0;
    ifc.cpu_we_i = 0; ifc.cpu_addr_i = 0; ifc.cpu_wdata_i = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_vmem_we", {31'd0, ifc.vmem_we_o}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_rdata", ifc.reg_rdata_o, 32'd0);

    // T1: 3x2 fill at (5,10)
    configure(16'h0A05, 9'd3, 9'd2, 16'hF800);
    reg_read(2'd0, rd);
    check("origin_readback", rd, 32'h0000_0A05);
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 3; i++) push_px(8'(5 + i), 8'(10 + j), 16'hF800);
    start_fill();
    wait_done("t1", 8);
    reg_read(2'd3, rd);
    check("t1_status", rd, 32'd2);
    reg_write(2'd3, 32'd2);
    reg_read(2'd3, rd);
    check("status_cleared", rd, 32'd0);

    // T2: right-edge clip
    configure(16'h00EE, 9'd5, 9'd1, 16'h001F);
    push_px(8'hEE, 8'h00, 16'h001F);
    push_px(8'hEF, 8'h00, 16'h001F);
    start_fill();
    wait_done("t2", 4);

    // T3: empty rectangles
    configure(16'h0000, 9'd0, 9'd2, 16'hFFFF);
    start_fill();
    wait_done("t3_w0", 2);
    configure(16'h00F0, 9'd3, 9'd2, 16'hFFFF);
    start_fill();
    wait_done("t3_x240", 2);

    // T4: CPU stores interleaved in fill cycles 3 and 4
    configure(16'h0A05, 9'd3, 9'd2, 16'hF800);
    push_px(8'h05, 8'h0A, 16'hF800);
    push_px(8'h06, 8'h0A, 16'hF800);
    exp_q.push_back(32'h1234_07E0);
    exp_q.push_back(32'h1234_07E0);
    push_px(8'h07, 8'h0A, 16'hF800);
    push_px(8'h05, 8'h0B, 16'hF800);
    push_px(8'h06, 8'h0B, 16'hF800);
    push_px(8'h07, 8'h0B, 16'hF800);
    start_fill();
    repeat (3) @(posedge clk);
    #1;
    ifc.cpu_we_i = 1'b1; ifc.cpu_addr_i = 16'h1234; ifc.cpu_wdata_i = 16'h07E0;
    repeat (2) @(posedge clk);
    #1;
    ifc.cpu_we_i = 1'b0;
    wait_done("t4", 10);

    // T5: abort a 16x16 fill after 10 pixels, then restart
    configure(16'h1010, 9'd16, 9'd16, 16'hAAAA);
    for (int i = 0; i < 10; i++) push_px(8'(16 + i), 8'h10, 16'hAAAA);
    n = wr_cnt + 10;
    start_fill();
    begin
      int k = 0;
      while (wr_cnt < n && k < 500) begin
        @(posedge clk);
        k++;
      end
    end
    #1;
    reg_write(2'd3, 32'd5);
    check("t5_busy_after_abort", {31'd0, busy}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("t5_no_done", 32'(done_cnt), 32'(done_before));
    check("t5_write_count", 32'(wr_cnt), 32'(n));
    reg_write(2'd1, {7'd0, 9'd1, 7'd0, 9'd1});
    push_px(8'h10, 8'h10, 16'hAAAA);
    start_fill();
    wait_done("t5_restart", 3);

    // T6a: start while busy is ignored
    configure(16'h2020, 9'd2, 9'd2, 16'h1234);
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 2; i++) push_px(8'(32 + i), 8'(32 + j), 16'h1234);
    start_fill();
    @(posedge clk);
    #1;
    check("t6_busy_in_fill", {31'd0, busy}, 32'd1);
    n = start_cyc;
    reg_write(2'd3, 32'd1);
    start_cyc = n;
    wait_done("t6_restart_ignored", 6);
    repeat (6) @(posedge clk);
    #1;
    check("t6_single_done", 32'(done_cnt - done_before), 32'd1);

    // T6b: reset mid-fill
    sb_off = 1'b1;
    configure(16'h0000, 9'd16, 9'd16, 16'h5555);
    start_fill();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_rst_vmem_we", {31'd0, ifc.vmem_we_o}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_done", {31'd0, done}, 32'd0);
    check("t6_rst_rdata", ifc.reg_rdata_o, 32'd0);
    sb_off = 1'b0;
    reg_read(2'd3, rd);
    check("t6_rst_status", rd, 32'd0);
    reg_read(2'd0, rd);
    check("t6_rst_origin", rd, 32'd0);

    // Bottom-right corner pixel
    configure(16'hEFEF, 9'd4, 9'd4, 16'h0F0F);
    push_px(8'hEF, 8'hEF, 16'h0F0F);
    start_fill();
    wait_done("corner", 3);

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
